// File: rtl/ice_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ice_bus_arbiter
//  Brief    : Shared slave-bus arbiter with fixed-priority / round-robin
//             selection, grant hold until tail, and a lockout watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module ice_bus_arbiter #(
    parameter int NUM_DEV   = 7,
    parameter int IDX_W     = 3,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_DEV-1:0]   sl_arb_request,
    input  logic                 sl_latch_tail,
    input  logic                 arb_mode,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    output logic [NUM_DEV-1:0]   sl_arb_grant,
    output logic                 arb_busy,
    output logic [IDX_W-1:0]     arb_owner,
    output logic                 arb_timeout,
    output logic [NUM_DEV-1:0]   arb_lockout
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_GRANT = 2'd1;
    localparam logic [1:0] c_ST_TURN  = 2'd2;

    localparam logic [NUM_DEV-1:0] c_ONE_HOT0 = NUM_DEV'(1);
    localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(NUM_DEV - 1);

    logic [1:0]           r_state;
    logic [NUM_DEV-1:0]   r_req;
    logic [NUM_DEV-1:0]   r_grant;
    logic                 r_busy;
    logic [IDX_W-1:0]     r_owner;
    logic                 r_timeout;
    logic [NUM_DEV-1:0]   r_lockout;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [TIMEOUT_W-1:0] r_count;

    logic [NUM_DEV-1:0]   w_eligible;
    logic [IDX_W-1:0]     w_fp_idx;
    logic [IDX_W-1:0]     w_rr_idx;
    logic [IDX_W-1:0]     w_win_idx;
    logic [NUM_DEV-1:0]   w_win_onehot;
    logic [IDX_W-1:0]     w_ptr_next;
    logic                 w_release;
    logic                 w_wd_fire;
    logic [NUM_DEV-1:0]   w_lock_set;
    int                   w_dist;
    int                   w_rr_best;

    // Arbitration works on the registered request so a new request costs one
    // sampling edge before it can win.
    assign w_eligible = r_req & ~r_lockout;

    always_comb begin
        w_fp_idx = '0;
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_fp_idx = IDX_W'(i);
            end
        end
    end

    // Round-robin: the eligible device with the smallest forward distance
    // from the pointer (modulo NUM_DEV) wins.
    always_comb begin
        w_rr_idx  = '0;
        w_rr_best = NUM_DEV;
        w_dist    = 0;
        for (int i = 0; i < NUM_DEV; i++) begin
            w_dist = i - int'(r_rr_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_DEV;
            end
            if (w_eligible[i] && (w_dist < w_rr_best)) begin
                w_rr_best = w_dist;
                w_rr_idx  = IDX_W'(i);
            end
        end
    end

    assign w_win_idx    = arb_mode ? w_rr_idx : w_fp_idx;
    assign w_win_onehot = c_ONE_HOT0 << w_win_idx;
    assign w_ptr_next   = (w_win_idx >= c_LAST_IDX) ? '0 : (w_win_idx + IDX_W'(1));

    // The owner's live request is picked out through its grant bit.
    assign w_release  = sl_latch_tail | ~(|(sl_arb_request & r_grant));
    assign w_wd_fire  = (r_state == c_ST_GRANT) && (timeout_cycles != '0) &&
                        (r_count == timeout_cycles) && !w_release;
    assign w_lock_set = w_wd_fire ? r_grant : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= c_ST_IDLE;
            r_req     <= '0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_owner   <= '0;
            r_timeout <= 1'b0;
            r_lockout <= '0;
            r_rr_ptr  <= '0;
            r_count   <= '0;
        end else begin
            r_req     <= sl_arb_request;
            r_timeout <= 1'b0;
            r_lockout <= (r_lockout | w_lock_set) & sl_arb_request;
            case (r_state)
                c_ST_IDLE: begin
                    if (|w_eligible) begin
                        r_grant <= w_win_onehot;
                        r_busy  <= 1'b1;
                        r_owner <= w_win_idx;
                        r_count <= TIMEOUT_W'(1);
                        if (arb_mode) begin
                            r_rr_ptr <= w_ptr_next;
                        end
                        r_state <= c_ST_GRANT;
                    end
                end
                c_ST_GRANT: begin
                    if (w_release) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= c_ST_TURN;
                    end else if (w_wd_fire) begin
                        r_grant   <= '0;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= c_ST_TURN;
                    end else if (r_count != '1) begin
                        r_count <= r_count + TIMEOUT_W'(1);
                    end
                end
                c_ST_TURN: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign sl_arb_grant = r_grant;
    assign arb_busy     = r_busy;
    assign arb_owner    = r_owner;
    assign arb_timeout  = r_timeout;
    assign arb_lockout  = r_lockout;

endmodule
`default_nettype wire

// File: tb/tb_ice_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ice_bus_arbiter
//  Brief    : Directed vector table plus hand-written round-robin, long-hold
//             and reset sequences for ice_bus_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ice_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  sl_arb_request;
    logic        sl_latch_tail;
    logic        arb_mode;
    logic [15:0] timeout_cycles;
    logic [6:0]  sl_arb_grant;
    logic        arb_busy;
    logic [2:0]  arb_owner;
    logic        arb_timeout;
    logic [6:0]  arb_lockout;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rst_n;
        logic [6:0]  req;
        logic        tail;
        logic [15:0] tmo;
        logic [6:0]  grant;
        logic        busy;
        logic [2:0]  owner;
        logic        tout;
        logic [6:0]  lock;
    } vec_t;

    vec_t vecs[$];

    ice_bus_arbiter #(.NUM_DEV(7), .IDX_W(3), .TIMEOUT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .sl_arb_request (sl_arb_request),
        .sl_latch_tail  (sl_latch_tail),
        .arb_mode       (arb_mode),
        .timeout_cycles (timeout_cycles),
        .sl_arb_grant   (sl_arb_grant),
        .arb_busy       (arb_busy),
        .arb_owner      (arb_owner),
        .arb_timeout    (arb_timeout),
        .arb_lockout    (arb_lockout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add_vec(input logic rst_n, input logic [6:0] req, input logic tail,
                           input logic [15:0] tmo, input logic [6:0] grant, input logic busy,
                           input logic [2:0] owner, input logic tout, input logic [6:0] lock);
        vec_t v;
        v.rst_n = rst_n; v.req = req; v.tail = tail; v.tmo = tmo;
        v.grant = grant; v.busy = busy; v.owner = owner; v.tout = tout; v.lock = lock;
        vecs.push_back(v);
    endtask

    task automatic wait_grant(input int idx);
        int n;
        n = 0;
        while (sl_arb_grant == 7'h00 && n < 10) begin
            tick();
            n++;
        end
        check("wait_grant", idx, 32'(sl_arb_grant != 7'h00), 32'd1);
    endtask

    initial begin
        int gap;
        int bad;
        int exp_owner;

        reset          = 1'b0;
        sl_arb_request = '0;
        sl_latch_tail  = 1'b0;
        arb_mode       = 1'b0;
        timeout_cycles = '0;

        //       rst  req    tail tmo  grant  busy own tout lock
        // fixed priority, tail handover, request-drop abort
        add_vec(1'b0, 7'h00, 1'b0, 16'd0, 7'h00, 1'b0, 3'd0, 1'b0, 7'h00);
        add_vec(1'b1, 7'h26, 1'b0, 16'd0, 7'h00, 1'b0, 3'd0, 1'b0, 7'h00);
        add_vec(1'b1, 7'h26, 1'b0, 16'd0, 7'h02, 1'b1, 3'd1, 1'b0, 7'h00);
        add_vec(1'b1, 7'h26, 1'b0, 16'd0, 7'h02, 1'b1, 3'd1, 1'b0, 7'h00);
        add_vec(1'b1, 7'h26, 1'b1, 16'd0, 7'h00, 1'b0, 3'd1, 1'b0, 7'h00);
        add_vec(1'b1, 7'h26, 1'b0, 16'd0, 7'h00, 1'b0, 3'd1, 1'b0, 7'h00);
        add_vec(1'b1, 7'h26, 1'b0, 16'd0, 7'h02, 1'b1, 3'd1, 1'b0, 7'h00);
        add_vec(1'b1, 7'h24, 1'b0, 16'd0, 7'h00, 1'b0, 3'd1, 1'b0, 7'h00);
        add_vec(1'b1, 7'h24, 1'b0, 16'd0, 7'h00, 1'b0, 3'd1, 1'b0, 7'h00);
        add_vec(1'b1, 7'h24, 1'b0, 16'd0, 7'h04, 1'b1, 3'd2, 1'b0, 7'h00);
        add_vec(1'b1, 7'h20, 1'b0, 16'd0, 7'h00, 1'b0, 3'd2, 1'b0, 7'h00);
        add_vec(1'b1, 7'h00, 1'b0, 16'd0, 7'h00, 1'b0, 3'd2, 1'b0, 7'h00);
        add_vec(1'b1, 7'h00, 1'b0, 16'd0, 7'h00, 1'b0, 3'd2, 1'b0, 7'h00);
        // watchdog at 5 cycles on device 3, lockout and its release
        add_vec(1'b1, 7'h08, 1'b0, 16'd5, 7'h00, 1'b0, 3'd2, 1'b0, 7'h00);
        add_vec(1'b1, 7'h08, 1'b0, 16'd5, 7'h08, 1'b1, 3'd3, 1'b0, 7'h00);
        add_vec(1'b1, 7'h08, 1'b0, 16'd5, 7'h08, 1'b1, 3'd3, 1'b0, 7'h00);
        add_vec(1'b1, 7'h08, 1'b0, 16'd5, 7'h08, 1'b1, 3'd3, 1'b0, 7'h00);
        add_vec(1'b1, 7'h08, 1'b0, 16'd5, 7'h08, 1'b1, 3'd3, 1'b0, 7'h00);
        add_vec(1'b1, 7'h08, 1'b0, 16'd5, 7'h08, 1'b1, 3'd3, 1'b0, 7'h00);
        add_vec(1'b1, 7'h08, 1'b0, 16'd5, 7'h00, 1'b0, 3'd3, 1'b1, 7'h08);
        add_vec(1'b1, 7'h08, 1'b0, 16'd5, 7'h00, 1'b0, 3'd3, 1'b0, 7'h08);
        add_vec(1'b1, 7'h08, 1'b0, 16'd5, 7'h00, 1'b0, 3'd3, 1'b0, 7'h08);
        add_vec(1'b1, 7'h08, 1'b0, 16'd5, 7'h00, 1'b0, 3'd3, 1'b0, 7'h08);
        add_vec(1'b1, 7'h00, 1'b0, 16'd5, 7'h00, 1'b0, 3'd3, 1'b0, 7'h00);
        add_vec(1'b1, 7'h08, 1'b0, 16'd5, 7'h00, 1'b0, 3'd3, 1'b0, 7'h00);
        add_vec(1'b1, 7'h08, 1'b0, 16'd5, 7'h08, 1'b1, 3'd3, 1'b0, 7'h00);
        add_vec(1'b1, 7'h00, 1'b0, 16'd5, 7'h00, 1'b0, 3'd3, 1'b0, 7'h00);
        add_vec(1'b1, 7'h00, 1'b0, 16'd5, 7'h00, 1'b0, 3'd3, 1'b0, 7'h00);
        // tail coincident with the timeout cycle is a normal release
        add_vec(1'b1, 7'h01, 1'b0, 16'd3, 7'h00, 1'b0, 3'd3, 1'b0, 7'h00);
        add_vec(1'b1, 7'h01, 1'b0, 16'd3, 7'h01, 1'b1, 3'd0, 1'b0, 7'h00);
        add_vec(1'b1, 7'h01, 1'b0, 16'd3, 7'h01, 1'b1, 3'd0, 1'b0, 7'h00);
        add_vec(1'b1, 7'h01, 1'b0, 16'd3, 7'h01, 1'b1, 3'd0, 1'b0, 7'h00);
        add_vec(1'b1, 7'h01, 1'b1, 16'd3, 7'h00, 1'b0, 3'd0, 1'b0, 7'h00);
        add_vec(1'b1, 7'h00, 1'b0, 16'd3, 7'h00, 1'b0, 3'd0, 1'b0, 7'h00);
        // tail outside a grant does nothing
        add_vec(1'b1, 7'h00, 1'b1, 16'd3, 7'h00, 1'b0, 3'd0, 1'b0, 7'h00);
        add_vec(1'b1, 7'h00, 1'b0, 16'd3, 7'h00, 1'b0, 3'd0, 1'b0, 7'h00);

        foreach (vecs[i]) begin
            reset          = vecs[i].rst_n;
            sl_arb_request = vecs[i].req;
            sl_latch_tail  = vecs[i].tail;
            timeout_cycles = vecs[i].tmo;
            tick();
            check("vec_grant", i, 32'(sl_arb_grant), 32'(vecs[i].grant));
            check("vec_busy",  i, 32'(arb_busy),     32'(vecs[i].busy));
            check("vec_owner", i, 32'(arb_owner),    32'(vecs[i].owner));
            check("vec_tout",  i, 32'(arb_timeout),  32'(vecs[i].tout));
            check("vec_lock",  i, 32'(arb_lockout),  32'(vecs[i].lock));
        end

        // Round-robin over all seven requesters, tail on every grant.
        sl_latch_tail  = 1'b0;
        timeout_cycles = 16'd0;
        reset          = 1'b0;
        tick();
        reset          = 1'b1;
        arb_mode       = 1'b1;
        sl_arb_request = 7'h7F;
        wait_grant(0);
        for (int k = 0; k < 8; k++) begin
            exp_owner = k % 7;
            check("rr_owner", k, 32'(arb_owner), 32'(exp_owner));
            check("rr_grant", k, 32'(sl_arb_grant), 32'd1 << exp_owner);
            if (k < 7) begin
                sl_latch_tail = 1'b1;
                tick();
                sl_latch_tail = 1'b0;
                gap = 0;
                while (sl_arb_grant == 7'h00 && gap < 10) begin
                    gap++;
                    tick();
                end
                check("rr_gap", k, 32'(gap), 32'd2);
            end
        end

        // Device 4 alone under round-robin, held 70000 cycles with the
        // watchdog disabled; moves the pointer away from 0.
        sl_arb_request = 7'h10;
        tick();
        wait_grant(1);
        check("long_owner", 0, 32'(arb_owner), 32'd4);
        bad = 0;
        for (int c = 0; c < 70000; c++) begin
            tick();
            if (sl_arb_grant !== 7'h10 || arb_timeout !== 1'b0) begin
                bad++;
            end
        end
        check("long_hold_bad_cycles", 0, 32'(bad), 32'd0);

        // Reset in the middle of the grant.
        reset = 1'b0;
        tick();
        check("rst_grant", 0, 32'(sl_arb_grant), 32'd0);
        check("rst_busy",  0, 32'(arb_busy),     32'd0);
        check("rst_owner", 0, 32'(arb_owner),    32'd0);
        check("rst_tout",  0, 32'(arb_timeout),  32'd0);
        check("rst_lock",  0, 32'(arb_lockout),  32'd0);
        reset          = 1'b1;
        sl_arb_request = 7'h7F;
        wait_grant(2);
        check("rst_rr_owner", 0, 32'(arb_owner),    32'd0);
        check("rst_rr_grant", 0, 32'(sl_arb_grant), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ice_bus_arbiter.md
Name: ice_bus_arbiter

Overview:
- Parametrised arbiter for the shared slave output bus (sl_data/sl_addr/sl_tail) that feeds the bus controller's UART TX path.
- Serves NUM_DEV requesters and supports two modes: fixed priority and round-robin.
- Holds each grant until the owner latches its tail or drops its request.
- A programmable watchdog revokes a stuck grant and locks that device out until it releases its request.
- Successor to the hard-wired 7-way arbitration; sits between the slave interfaces (basics, mbus, ein, pmu, …) and the bus controller.

Parameters:
- NUM_DEV, 7, number of requesters (>=2).
- IDX_W, 3, width of device index; must satisfy 2^IDX_W >= NUM_DEV.
- TIMEOUT_W, 16, width of the watchdog counter and of timeout_cycles.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- sl_arb_request  input  NUM_DEV  per-device bus request, level.
- sl_latch_tail  input  1  owner's end-of-frame strobe, one cycle.
- arb_mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- timeout_cycles  input  TIMEOUT_W  grant watchdog limit in cycles; 0 disables it.
- sl_arb_grant  output  NUM_DEV  one-hot grant, registered.
- arb_busy  output  1  high while any grant is asserted.
- arb_owner  output  IDX_W  index of the current or most recent owner.
- arb_timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog.
- arb_lockout  output  NUM_DEV  devices currently locked out.

Behaviour:
- Reset (reset==0 at a clk edge): on the next edge sl_arb_grant=0, arb_busy=0, arb_owner=0, arb_timeout=0, arb_lockout=0, rr pointer=0, watchdog counter=0, state=IDLE. This applies mid-grant too: the grant drops the following cycle and no tail is required.
- State IDLE:
  - eligible = sl_arb_request & ~arb_lockout.
  - If eligible is nonzero, select a winner, register its one-hot grant, set arb_owner, load counter=1, go to GRANT.
  - Latency: a request first sampled at edge N gives a grant visible after edge N+1.
- Selection, arb_mode==0: the lowest-index eligible device wins.
- Selection, arb_mode==1: search upward from the rr pointer, wrapping modulo NUM_DEV. The first eligible device wins. On each grant the pointer is set to winner+1, wrapping NUM_DEV-1 to 0.
- arb_mode is sampled only in IDLE. Changing it during GRANT has no effect until the next arbitration.
- State GRANT:
  - The grant is held and the counter increments each cycle, saturating at all-ones.
  - Normal release: sl_latch_tail==1, or the owner's request is 0. The grant clears on the next edge; go to TURN.
  - Watchdog: timeout_cycles!=0 and counter==timeout_cycles and no release condition this cycle. The grant clears on the next edge, arb_timeout pulses for exactly one cycle coincident with the grant falling, arb_lockout[owner] is set, go to TURN.
  - A release condition and the timeout in the same cycle count as a normal release: no pulse, no lockout.
  - sl_latch_tail outside GRANT is ignored.
- State TURN: one dead cycle with no grant, then IDLE. Minimum gap between consecutive grants is 2 cycles, so a back-to-back owner handover is grant-low for exactly 2 cycles.
- Lockout clearing: arb_lockout[i] clears on any cycle where sl_arb_request[i]==0, in every state.
- arb_busy equals |sl_arb_grant (registered, same cycle). arb_owner holds its value after release.
- sl_arb_grant is never more than one-hot, and is never asserted to a device whose lockout bit is set or whose request was 0 when sampled at arbitration.

Test Plan:
- Fixed priority: arb_mode=0, requests 0b0100110 held.
  - Required: grant 0b0000010, owner=1.
  - Tail pulse → grant 0 for 2 cycles, then 0b0000010 again (device 1 still requesting).
- Round-robin: arb_mode=1, all 7 requesting, tail pulsed on every grant.
  - Required: owners cycle 0,1,2,3,4,5,6,0 with exactly 2 idle cycles between grants.
- Watchdog: timeout_cycles=5, device 3 requests and never tails.
  - Required: grant held 5 cycles, then arb_timeout pulses once and arb_lockout=0b0001000.
  - Device 3 is not re-granted while its request stays high.
  - Deassert its request for 1 cycle → lockout clears; on re-request it is granted.
- Tail/timeout collision: timeout_cycles=3, tail pulsed on the 3rd grant cycle.
  - Required: normal release, arb_timeout stays 0, arb_lockout stays 0.
- Request drop as abort, plus watchdog disabled: owner 2 drops its request mid-grant with no tail.
  - Required: grant clears next cycle, then TURN.
  - With timeout_cycles=0, a 70000-cycle grant is never revoked (counter saturates, no pulse).
- Reset mid-grant: assert reset low for 1 cycle while device 4 is granted.
  - Required: next cycle all outputs 0, rr pointer 0.
  - With mode 1 and all requesting after reset, first owner=0.
